// File: rtl/scan_pkg.sv
// Shared constants and state encoding for the scan sequencer and the decoder bench.
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        BLANK = 2'd2
    } scan_state_t;

    localparam int SCAN_N            = 3;
    localparam int SCAN_BLANK_CYCLES = 2;

endpackage

// File: rtl/scan_next_idx.sv
// Circular priority finder: first set mask bit strictly after idx, wrapping around
// to idx itself last. wrap is set when the found index is not above idx.
module scan_next_idx #(
    parameter int N = 3
) (
    input  logic [2**N-1:0] mask,
    input  logic [N-1:0]    idx,
    output logic [N-1:0]    nxt,
    output logic            wrap
);

    logic [N-1:0] cand;

    // Walking offsets from farthest to nearest lets the nearest hit win.
    always_comb begin
        nxt  = idx;
        cand = '0;
        for (int k = 2**N; k >= 1; k--) begin
            cand = idx + N'(k);
            if (mask[cand]) begin
                nxt = cand;
            end
        end
    end

    assign wrap = (nxt <= idx);

endmodule

// File: rtl/scan_sequencer.sv
// Stepping select generator for a one-hot decoder: each enabled slot is driven for a
// programmable dwell, followed by a fixed blanking gap; single-frame or continuous.
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int N            = SCAN_N,
    parameter int DWELL_W      = 8,
    parameter int BLANK_CYCLES = SCAN_BLANK_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               cont,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [2**N-1:0]    mask,
    output logic [N-1:0]       sel,
    output logic               sel_valid,
    output logic               busy,
    output logic               frame_done,
    output logic [1:0]         dbg_state
);

    localparam int BW = $clog2(BLANK_CYCLES + 1);

    scan_state_t        state;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [DWELL_W-1:0] dwell_lat;
    logic [BW-1:0]      blank_cnt;
    logic [2**N-1:0]    mask_lat;
    logic               cont_lat;

    logic [DWELL_W-1:0] dwell_eff;
    logic [2**N-1:0]    find_mask;
    logic [N-1:0]       find_idx;
    logic [N-1:0]       nxt_idx;
    logic               nxt_wrap;

    assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

    // In IDLE an all-ones index makes the finder return the lowest set bit of the live mask.
    assign find_mask = (state == IDLE) ? mask : mask_lat;
    assign find_idx  = (state == IDLE) ? '1   : sel;

    scan_next_idx #(.N(N)) u_next (
        .mask (find_mask),
        .idx  (find_idx),
        .nxt  (nxt_idx),
        .wrap (nxt_wrap)
    );

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        frame_done <= 1'b0;
        if (rst) begin
            state      <= IDLE;
            sel        <= '0;
            sel_valid  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            dwell_cnt  <= '0;
            dwell_lat  <= '0;
            blank_cnt  <= '0;
            mask_lat   <= '0;
            cont_lat   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !stop && (mask != '0)) begin
                        dwell_lat <= dwell_eff;
                        mask_lat  <= mask;
                        cont_lat  <= cont;
                        sel       <= nxt_idx;
                        sel_valid <= 1'b1;
                        busy      <= 1'b1;
                        dwell_cnt <= dwell_eff;
                        state     <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (stop) begin
                        sel_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (dwell_cnt <= DWELL_W'(1)) begin
                        sel_valid <= 1'b0;
                        blank_cnt <= BW'(BLANK_CYCLES);
                        state     <= BLANK;
                    end else begin
                        dwell_cnt <= dwell_cnt - DWELL_W'(1);
                    end
                end
                BLANK: begin
                    if (stop) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (blank_cnt <= BW'(1)) begin
                        // A wrap (or a single-bit mask returning itself) closes the frame.
                        if (nxt_wrap && !cont_lat) begin
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            frame_done <= nxt_wrap;
                            sel        <= nxt_idx;
                            sel_valid  <= 1'b1;
                            dwell_cnt  <= dwell_lat;
                            state      <= DRIVE;
                        end
                    end else begin
                        blank_cnt <= blank_cnt - BW'(1);
                    end
                end
                default: begin
                    sel_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer: hand-computed slot timing, skip/wrap, stop, reset
// and a one-hot decode of sel gated by sel_valid.
module tb_scan_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic       cont;
    logic [7:0] dwell;
    logic [7:0] mask;
    logic [2:0] sel;
    logic       sel_valid;
    logic       busy;
    logic       frame_done;
    logic [1:0] dbg_state;

    int checks;
    int failures;

    scan_sequencer #(.N(3), .DWELL_W(8), .BLANK_CYCLES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .cont       (cont),
        .dwell      (dwell),
        .mask       (mask),
        .sel        (sel),
        .sel_valid  (sel_valid),
        .busy       (busy),
        .frame_done (frame_done),
        .dbg_state  (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic pulse_start(input logic [7:0] m, input logic [7:0] d, input logic c);
        mask  = m;
        dwell = d;
        cont  = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (sel !== 3'd0 || sel_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 || dbg_state !== 2'd0) begin
            failures++;
            $display("FAIL reset_init sel=%0d valid=%b busy=%b done=%b state=%0d expected all 0", sel, sel_valid, busy, frame_done, dbg_state);
        end
        rst = 1'b0;
        pulse_start(8'hFF, 8'd3, 1'b0);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (sel !== 3'd0 || sel_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid sel=%0d valid=%b busy=%b done=%b expected all 0", sel, sel_valid, busy, frame_done);
        end
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            checks++;
            if (frame_done !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL reset_quiet t=%0d done=%b busy=%b expected 0 0", t, frame_done, busy);
            end
        end
    endtask

    task automatic test_full_frame();
        logic [2:0] e_sel;
        logic       e_valid;
        pulse_start(8'hFF, 8'd3, 1'b0);
        // Mid-frame input changes must be ignored.
        mask  = 8'h01;
        dwell = 8'd7;
        cont  = 1'b1;
        for (int t = 0; t < 40; t++) begin
            e_sel   = 3'(t / 5);
            e_valid = ((t % 5) < 3);
            start   = (t == 12);
            checks++;
            if (sel !== e_sel || sel_valid !== e_valid || busy !== 1'b1 || frame_done !== 1'b0) begin
                failures++;
                $display("FAIL full_frame t=%0d sel=%0d valid=%b busy=%b done=%b expected sel=%0d valid=%b busy=1 done=0",
                         t, sel, sel_valid, busy, frame_done, e_sel, e_valid);
            end
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (frame_done !== 1'b1 || busy !== 1'b0 || sel !== 3'd7 || sel_valid !== 1'b0) begin
            failures++;
            $display("FAIL full_frame_end done=%b busy=%b sel=%0d valid=%b expected 1 0 7 0", frame_done, busy, sel, sel_valid);
        end
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b0 || busy !== 1'b0 || sel !== 3'd7) begin
            failures++;
            $display("FAIL full_frame_after done=%b busy=%b sel=%0d expected 0 0 7", frame_done, busy, sel);
        end
    endtask

    task automatic test_mask_skip();
        logic [2:0] seq [3];
        logic [2:0] e_sel;
        seq[0] = 3'd0;
        seq[1] = 3'd2;
        seq[2] = 3'd7;
        pulse_start(8'b1000_0101, 8'd1, 1'b1);
        for (int t = 0; t < 27; t++) begin
            e_sel = seq[(t / 3) % 3];
            checks++;
            if (sel !== e_sel || sel_valid !== ((t % 3) == 0) || busy !== 1'b1 ||
                frame_done !== ((t > 0) && ((t % 9) == 0))) begin
                failures++;
                $display("FAIL mask_skip t=%0d sel=%0d valid=%b busy=%b done=%b expected sel=%0d valid=%b busy=1 done=%b",
                         t, sel, sel_valid, busy, frame_done, e_sel, ((t % 3) == 0), ((t > 0) && ((t % 9) == 0)));
            end
            @(negedge clk);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || sel_valid !== 1'b0 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL mask_skip_stop busy=%b valid=%b done=%b expected 0 0 0", busy, sel_valid, frame_done);
        end
    endtask

    task automatic test_degenerate();
        pulse_start(8'h00, 8'd3, 1'b1);
        for (int t = 0; t < 4; t++) begin
            checks++;
            if (busy !== 1'b0 || sel_valid !== 1'b0) begin
                failures++;
                $display("FAIL zero_mask t=%0d busy=%b valid=%b expected 0 0", t, busy, sel_valid);
            end
            @(negedge clk);
        end
        // dwell=0 behaves as 1: slots at t=0 and t=3, frame ends at t=6.
        pulse_start(8'b0000_0011, 8'd0, 1'b0);
        for (int t = 0; t < 7; t++) begin
            checks++;
            if (sel_valid !== ((t == 0) || (t == 3)) || sel !== ((t < 3) ? 3'd0 : 3'd1) ||
                frame_done !== (t == 6) || busy !== (t < 6)) begin
                failures++;
                $display("FAIL dwell_zero t=%0d sel=%0d valid=%b done=%b busy=%b", t, sel, sel_valid, frame_done, busy);
            end
            @(negedge clk);
        end
        pulse_start(8'b0001_0000, 8'd1, 1'b1);
        for (int t = 0; t < 13; t++) begin
            checks++;
            if (sel !== 3'd4 || sel_valid !== ((t % 3) == 0) || frame_done !== ((t > 0) && ((t % 3) == 0))) begin
                failures++;
                $display("FAIL single_bit t=%0d sel=%0d valid=%b done=%b expected sel=4 valid=%b done=%b",
                         t, sel, sel_valid, frame_done, ((t % 3) == 0), ((t > 0) && ((t % 3) == 0)));
            end
            @(negedge clk);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || sel !== 3'd4) begin
            failures++;
            $display("FAIL single_bit_stop busy=%b sel=%0d expected 0 4", busy, sel);
        end
    endtask

    task automatic test_stop();
        pulse_start(8'hFF, 8'd3, 1'b0);
        repeat (16) @(negedge clk);
        checks++;
        if (sel !== 3'd3 || sel_valid !== 1'b1) begin
            failures++;
            $display("FAIL stop_setup sel=%0d valid=%b expected 3 1", sel, sel_valid);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        checks++;
        if (sel !== 3'd3 || sel_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL stop_drive sel=%0d valid=%b busy=%b done=%b expected 3 0 0 0", sel, sel_valid, busy, frame_done);
        end
        for (int t = 0; t < 45; t++) begin
            @(negedge clk);
            checks++;
            if (frame_done !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL stop_quiet t=%0d done=%b busy=%b expected 0 0", t, frame_done, busy);
            end
        end
        stop = 1'b1;
        pulse_start(8'hFF, 8'd3, 1'b0);
        stop = 1'b0;
        for (int t = 0; t < 3; t++) begin
            checks++;
            if (busy !== 1'b0 || sel_valid !== 1'b0 || sel !== 3'd3) begin
                failures++;
                $display("FAIL start_with_stop t=%0d busy=%b valid=%b sel=%0d expected 0 0 3", t, busy, sel_valid, sel);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_decoder();
        logic [7:0] onehot;
        logic [7:0] exp_oh;
        logic [7:0] one;
        one = 8'h01;
        pulse_start(8'hFF, 8'd1, 1'b0);
        for (int t = 0; t < 25; t++) begin
            onehot = sel_valid ? (one << sel) : 8'h00;
            exp_oh = ((t < 24) && ((t % 3) == 0)) ? (one << (t / 3)) : 8'h00;
            checks++;
            if (onehot !== exp_oh || frame_done !== (t == 24)) begin
                failures++;
                $display("FAIL decoder t=%0d out=%h done=%b expected out=%h done=%b", t, onehot, frame_done, exp_oh, (t == 24));
            end
            @(negedge clk);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        start    = 1'b0;
        stop     = 1'b0;
        cont     = 1'b0;
        dwell    = 8'd0;
        mask     = 8'd0;
        @(negedge clk);
        test_reset();
        test_full_frame();
        test_mask_skip();
        test_degenerate();
        test_stop();
        test_decoder();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scan_sequencer.md
Name: scan_sequencer

Overview:
- Upstream driver for the 3-to-8 decoder: generates a stepping select index `sel` plus a qualifying `sel_valid`, so the decoder's one-hot output can scan rows, columns or chip-selects.
- Each slot is held for a programmable dwell time and followed by a fixed blanking gap.
- Masked slots are skipped.
- Supports single-frame and continuous scanning.

Parameters:
- N, 3: select width; 2**N slots; matches decoder input width.
- DWELL_W, 8: width of the dwell-count input.
- BLANK_CYCLES, 2: cycles of `sel_valid`=0 between slots; minimum 1.

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a frame; honoured only in IDLE.
- stop  input  1  abort request; honoured in any state.
- cont  input  1  1 = wrap and keep scanning after the last slot; 0 = single frame. Sampled at start.
- dwell  input  DWELL_W  cycles per slot with `sel_valid`=1; 0 is treated as 1. Sampled at start.
- mask  input  2**N  bit i=1 enables slot i. Sampled at start.
- sel  output  N  current slot index; feeds decoder `in`.
- sel_valid  output  1  high while the slot is being driven; gates the decoder output.
- busy  output  1  high in DRIVE or BLANK.
- frame_done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset:
  - Clock is `clk`; reset `rst` is synchronous and active-high. A reset takes effect on the clk edge where `rst`=1.
  - Reset values: state=IDLE, sel=0, sel_valid=0, busy=0, frame_done=0. Latched dwell, mask and cont are cleared.
  - Reset mid-frame aborts immediately with no frame_done pulse.
- Registers and timing:
  - All outputs are registered.
  - "Edge k" means the rising edge at which an input is sampled; outputs change after that edge.
- States:
  - IDLE:
    - start=1, stop=0 and mask≠0 at edge k:
      - latch dwell_eff = max(dwell,1), mask and cont;
      - sel = lowest set mask bit; sel_valid=1; busy=1; load dwell counter; go DRIVE.
      - Latency: `sel_valid` rises on the edge that samples start.
    - start with mask=0 is ignored; stay IDLE.
    - start with stop in the same cycle: stop wins; stay IDLE.
  - DRIVE:
    - sel_valid=1 for exactly dwell_eff cycles.
    - On expiry, go BLANK: sel_valid=0, sel held, blank counter loaded.
  - BLANK:
    - sel_valid=0 for exactly BLANK_CYCLES cycles. On expiry, compute the next index as the first set latched-mask bit searching circularly upward from sel+1.
    - If the search wraps, or returns the same index (single-bit mask), the frame is complete. frame_done=1 for that one cycle, then:
      - cont=1: go DRIVE at the next index, sel_valid=1, busy stays 1;
      - cont=0: go IDLE, busy=0, sel unchanged.
    - Otherwise, go DRIVE at the next index.
- Stop: stop=1 in DRIVE or BLANK at edge k gives IDLE after edge k, with sel_valid=0, busy=0, sel held and no frame_done.
- Start while busy is ignored.
- Changes to mask, dwell or cont during a frame have no effect until the next start.
- Counter widths:
  - dwell counter is DWELL_W bits, counting down to 1;
  - blank counter is $clog2(BLANK_CYCLES+1) bits.
- Index arithmetic is modulo 2**N: sel=7 plus 1 gives 0.
- Frame period = popcount(mask)·(dwell_eff+BLANK_CYCLES) cycles.
- Invariant: sel_valid=1 implies mask_latched[sel]=1.

Decomposition:
- Shared package `scan_pkg`:
  - state encoding constants IDLE=2'd0, DRIVE=2'd1, BLANK=2'd2;
  - default N and BLANK_CYCLES constants, shared with the decoder bench.
- One sub-module: `scan_next_idx`, a purely combinational circular priority finder.
  - Inputs: mask, current index.
  - Outputs: next index, wrap flag.
- The top level holds the FSM, counters and output registers.

Test Plan:
- Reset: drive rst=1 for 2 cycles mid-frame (mask=8'hFF, dwell=3) -> next cycle sel=0, sel_valid=0, busy=0, frame_done=0; no stray pulse afterwards.
- Full single frame: mask=8'hFF, dwell=3, cont=0, BLANK_CYCLES=2, start pulse.
  - sel steps 0..7, each with sel_valid high 3 cycles then low 2 cycles.
  - frame_done pulses exactly once, 40 cycles after start; busy=0 afterwards; sel=7.
- Masked skip with wrap: mask=8'b1000_0101, dwell=1, cont=1.
  - sel sequence is 0,2,7,0,2,7…
  - frame_done pulses at each 7->0 transition, every 9 cycles.
- Degenerate inputs:
  - mask=0 with start -> busy stays 0.
  - dwell=0 -> each slot gets sel_valid high 1 cycle.
  - mask=8'b0001_0000 with cont=1 -> sel stays 4, frame_done every 3 cycles.
- Stop mid-slot: stop during DRIVE of sel=3 -> next cycle sel_valid=0, busy=0, sel=3, no frame_done. start together with stop in IDLE -> ignored.
- Decoder integration: feed sel into decoder3x8 and gate its out with sel_valid -> observed one-hot sequence 8'h01, 8'h02, …, 8'h80 with 8'h00 during blanking.
